// File: rtl/tap_sequencer_pkg.sv
// Shared definitions for the bicubic tap sequencer: default geometry,
// slot length and the sequencer FSM state encoding.
package tap_sequencer_pkg;

  localparam int IMG_W_DEF   = 100;
  localparam int ADDR_W_DEF  = 14;
  localparam int COORD_W_DEF = 7;

  // cycles per target pixel: one idle ROM-setup phase plus four taps
  localparam int NUM_PHASES  = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/tap_sequencer_frac_div.sv
// Radix-4 restoring divider: q = floor(num*256/den), 8-bit result, with
// num < den. start loads num and performs the first digit step in the same
// cycle; three further steps follow, so q is complete after 4 edges.
//   CLK, RST (async, active low)
//   start : load num and begin a division
//   num   : remainder (numerator before the *256 scaling)
//   den   : divisor, nonzero
//   q     : quotient, valid after the 4th step until the next start
module tap_sequencer_frac_div
  import tap_sequencer_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [COORD_W-1:0] num,
  input  logic [COORD_W-1:0] den,
  output logic [7:0]         q
);

  // partial remainder stays below den, so 4*den needs two extra bits
  localparam int RW = COORD_W + 3;

  logic [RW-1:0] r_q, r_d;
  logic [7:0]    q_q, q_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          act_q, act_d;

  logic [RW-1:0] r_in, r_sh, d1, d2, d3, sub;
  logic [1:0]    dig;

  always_comb begin
    r_in = start ? RW'(num) : r_q;
    // the low dividend bits are all zero, so each step just shifts in 2'b00
    r_sh = r_in << 2;
    d1   = RW'(den);
    d2   = d1 << 1;
    d3   = d1 + d2;
    if      (r_sh >= d3) begin dig = 2'd3; sub = d3;  end
    else if (r_sh >= d2) begin dig = 2'd2; sub = d2;  end
    else if (r_sh >= d1) begin dig = 2'd1; sub = d1;  end
    else                 begin dig = 2'd0; sub = '0;  end

    r_d   = r_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    act_d = act_q;
    if (start || act_q) begin
      r_d   = r_sh - sub;
      q_d   = {start ? 6'd0 : q_q[5:0], dig};
      cnt_d = start ? 2'd1 : cnt_q + 2'd1;
      act_d = start ? 1'b1 : (cnt_q != 2'd3);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tap_sequencer.sv
// Feeder for the bicubic horizontal stage. On start it walks SH source rows
// by TW target columns, and for every target pixel runs a 5-cycle slot:
// rom_addr steps through taps -1..2 in phases 0..3, P_out returns them in
// phases 1..4, X_out holds {x, x^2, x^3} for the whole slot. The fraction
// for the next slot is divided during phases 0..3 and cubed in phase 4.
//   CLK, RST (async, active low)
//   start, V0/H0/SW/SH/TW/TH : frame request and geometry (sampled on start)
//   rom_addr / rom_q         : image ROM, one-cycle read latency
//   P_out, X_out             : tap pixel and packed weight powers
//   phase, tap_valid         : slot phase 0..4, high in phases 1..4
//   busy, done               : frame in progress / one-cycle completion
module tap_sequencer
  import tap_sequencer_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [COORD_W-1:0] V0,
  input  logic [COORD_W-1:0] H0,
  input  logic [COORD_W-1:0] SW,
  input  logic [COORD_W-1:0] SH,
  input  logic [COORD_W-1:0] TW,
  input  logic [COORD_W-1:0] TH,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [7:0]         rom_q,
  output logic [7:0]         P_out,
  output logic [23:0]        X_out,
  output logic [2:0]         phase,
  output logic               tap_valid,
  output logic               busy,
  output logic               done
);

  localparam int CW = COORD_W;
  localparam int PW = COORD_W + 2;
  localparam logic [2:0] PH_LAST = 3'(NUM_PHASES - 1);

  state_e         st_q, st_d;
  logic [2:0]     ph_q, ph_d;
  logic [CW-1:0]  v0_q, v0_d, h0_q, h0_d, sw_q, sw_d, sh_q, sh_d, tw_q, tw_d;
  logic [CW-1:0]  tx_q, tx_d, ix_q, ix_d, rem_q, rem_d, r_q, r_d;
  logic [23:0]    x_q, x_d;

  // TH only matters to the vertical pass downstream
  logic unused_th;
  assign unused_th = ^TH;

  logic [CW-1:0]  dm1, swm1, nrem, nix, div_num, col;
  logic [CW:0]    rem_sum;
  logic           wrap, last_col, last_row, div_start, run;
  logic [7:0]     div_q, x2, x3;
  logic [1:0]     tsel;
  logic [PW-1:0]  pos, pm1;
  logic [ADDR_W-1:0] addr;

  assign dm1  = tw_q - CW'(1);
  assign swm1 = sw_q - CW'(1);
  assign run  = (st_q == S_RUN);

  // position of the following column; SW <= TW keeps it to one wrap
  always_comb begin
    rem_sum  = {1'b0, rem_q} + {1'b0, swm1};
    wrap     = (rem_sum >= {1'b0, dm1});
    nrem     = wrap ? CW'(rem_sum - {1'b0, dm1}) : CW'(rem_sum);
    nix      = ix_q + CW'(wrap);
    last_col = (tx_q == dm1);
    last_row = (r_q == sh_q - CW'(1));
  end

  // PREP divides for slot 0 (rem 0); RUN divides for the slot after this one
  assign div_num   = (run && !last_col) ? nrem : '0;
  assign div_start = (st_q == S_PREP || run) && (ph_q == 3'd0);

  tap_sequencer_frac_div #(.COORD_W(COORD_W)) u_div (
    .CLK   (CLK),
    .RST   (RST),
    .start (div_start),
    .num   (div_num),
    .den   (dm1),
    .q     (div_q)
  );

  assign x2 = 8'((16'(div_q) * 16'(div_q)) >> 8);
  assign x3 = 8'((16'(x2) * 16'(div_q)) >> 8);

  // tap index t = tsel-1; pos = ix+t+1 keeps the arithmetic unsigned
  always_comb begin
    tsel = (ph_q >= 3'd3) ? 2'd3 : ph_q[1:0];
    pos  = {2'b00, ix_q} + PW'(tsel);
    pm1  = pos - PW'(1);
    if (pos == '0)             col = '0;
    else if (pm1 > PW'(swm1))  col = swm1;
    else                       col = pm1[CW-1:0];
    addr = (ADDR_W'(v0_q) + ADDR_W'(r_q)) * ADDR_W'(IMG_W)
         + ADDR_W'(h0_q) + ADDR_W'(col);
  end

  always_comb begin
    st_d  = st_q;
    ph_d  = ph_q;
    v0_d  = v0_q;
    h0_d  = h0_q;
    sw_d  = sw_q;
    sh_d  = sh_q;
    tw_d  = tw_q;
    tx_d  = tx_q;
    ix_d  = ix_q;
    rem_d = rem_q;
    r_d   = r_q;
    x_d   = x_q;
    case (st_q)
      S_IDLE: if (start) begin
        v0_d  = V0;
        h0_d  = H0;
        sw_d  = SW;
        sh_d  = SH;
        tw_d  = TW;
        tx_d  = '0;
        ix_d  = '0;
        rem_d = '0;
        r_d   = '0;
        ph_d  = '0;
        st_d  = S_PREP;
      end
      S_PREP: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          x_d  = {div_q, x2, x3};
          st_d = S_RUN;
        end else begin
          ph_d = ph_q + 3'd1;
        end
      end
      S_RUN: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          x_d  = {div_q, x2, x3};
          if (last_col) begin
            tx_d  = '0;
            ix_d  = '0;
            rem_d = '0;
            r_d   = r_q + CW'(1);
            if (last_row) st_d = S_DONE;
          end else begin
            tx_d  = tx_q + CW'(1);
            ix_d  = nix;
            rem_d = nrem;
          end
        end else begin
          ph_d = ph_q + 3'd1;
        end
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st_q  <= S_IDLE;
      ph_q  <= '0;
      v0_q  <= '0;
      h0_q  <= '0;
      sw_q  <= '0;
      sh_q  <= '0;
      tw_q  <= '0;
      tx_q  <= '0;
      ix_q  <= '0;
      rem_q <= '0;
      r_q   <= '0;
      x_q   <= '0;
    end else begin
      st_q  <= st_d;
      ph_q  <= ph_d;
      v0_q  <= v0_d;
      h0_q  <= h0_d;
      sw_q  <= sw_d;
      sh_q  <= sh_d;
      tw_q  <= tw_d;
      tx_q  <= tx_d;
      ix_q  <= ix_d;
      rem_q <= rem_d;
      r_q   <= r_d;
      x_q   <= x_d;
    end
  end

  assign rom_addr  = run ? addr : '0;
  assign phase     = run ? ph_q : '0;
  assign tap_valid = run && (ph_q != 3'd0);
  assign P_out     = tap_valid ? rom_q : 8'd0;
  assign X_out     = x_q;
  assign busy      = (st_q == S_PREP) || run;
  assign done      = (st_q == S_DONE);

endmodule

// File: tb/tb_tap_sequencer.sv
module tb_tap_sequencer;

  localparam int IMG_W = 100;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  V0 = '0, H0 = '0, SW = '0, SH = '0, TW = '0, TH = '0;
  logic [13:0] rom_addr;
  logic [7:0]  rom_q = '0;
  logic [7:0]  P_out;
  logic [23:0] X_out;
  logic [2:0]  phase;
  logic        tap_valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  tap_sequencer dut (
    .CLK(CLK), .RST(RST), .start(start),
    .V0(V0), .H0(H0), .SW(SW), .SH(SH), .TW(TW), .TH(TH),
    .rom_addr(rom_addr), .rom_q(rom_q), .P_out(P_out), .X_out(X_out),
    .phase(phase), .tap_valid(tap_valid), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // ROM[a] = a (8-bit data), one-cycle read latency
  always @(posedge CLK) rom_q <= 8'(rom_addr);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int sw, tw, sh, v0, h0, row, tx;
    logic [23:0] x;
    int c0, c1, c2, c3;   // clamped tap columns relative to H0
  } vec_t;

  vec_t vecs[12];

  task automatic start_frame(input int sw, input int tw, input int sh, input int v0, input int h0);
    @(posedge CLK); #1;
    SW = 7'(sw); TW = 7'(tw); SH = 7'(sh); V0 = 7'(v0); H0 = 7'(h0); TH = 7'(sh);
    start = 1'b1;
    @(posedge CLK); #1;   // start sampled at this edge (k); now in cycle k+1
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    check(name, 32'(done), 32'd1);
    @(posedge CLK); #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cols[4];
    int a, prev;
    cols = '{v.c0, v.c1, v.c2, v.c3};
    prev = 0;
    start_frame(v.sw, v.tw, v.sh, v.v0, v.h0);
    repeat (5 + 5 * (v.row * v.tw + v.tx)) begin @(posedge CLK); #1; end
    for (int p = 0; p < 5; p++) begin
      a = (v.v0 + v.row) * IMG_W + v.h0 + cols[(p > 3) ? 3 : p];
      check($sformatf("v%0d phase p%0d", idx, p), 32'(phase), 32'(p));
      check($sformatf("v%0d tap_valid p%0d", idx, p), 32'(tap_valid), 32'(p != 0));
      check($sformatf("v%0d X_out p%0d", idx, p), 32'(X_out), 32'(v.x));
      check($sformatf("v%0d rom_addr p%0d", idx, p), 32'(rom_addr), 32'(a));
      if (p > 0)
        check($sformatf("v%0d P_out p%0d", idx, p), 32'(P_out), 32'(prev & 255));
      prev = a;
      @(posedge CLK); #1;
    end
    wait_done($sformatf("v%0d done", idx));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rom_addr"},  32'(rom_addr),  32'd0);
    check({tag, " P_out"},     32'(P_out),     32'd0);
    check({tag, " X_out"},     32'(X_out),     32'd0);
    check({tag, " phase"},     32'(phase),     32'd0);
    check({tag, " tap_valid"}, 32'(tap_valid), 32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " done"},      32'(done),      32'd0);
  endtask

  initial begin
    int first_tv, ndone;

    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RST = 1'b1;
    @(posedge CLK); #1;
    check_all_zero("idle");

    //            sw tw sh v0 h0 row tx  x           c-1 c0 c1 c2
    vecs[0]  = '{3, 4, 1, 0, 0,  0, 0, 24'h000000, 0, 0, 1, 2};
    vecs[1]  = '{3, 4, 1, 0, 0,  0, 1, 24'hAA704A, 0, 0, 1, 2};
    vecs[2]  = '{3, 4, 1, 0, 0,  0, 2, 24'h551C09, 0, 1, 2, 2};
    vecs[3]  = '{3, 4, 1, 0, 0,  0, 3, 24'h000000, 1, 2, 2, 2};
    vecs[4]  = '{4, 4, 1, 0, 10, 0, 0, 24'h000000, 0, 0, 1, 2};
    vecs[5]  = '{4, 4, 1, 0, 10, 0, 3, 24'h000000, 2, 3, 3, 3};
    vecs[6]  = '{2, 2, 2, 5, 0,  1, 0, 24'h000000, 0, 0, 1, 1};
    vecs[7]  = '{2, 2, 2, 5, 0,  1, 1, 24'h000000, 0, 1, 1, 1};
    vecs[8]  = '{5, 5, 1, 0, 0,  0, 2, 24'h000000, 1, 2, 3, 4};
    vecs[9]  = '{5, 5, 1, 0, 0,  0, 4, 24'h000000, 3, 4, 4, 4};
    vecs[10] = '{2, 4, 1, 0, 0,  0, 1, 24'h551C09, 0, 0, 1, 1};
    vecs[11] = '{3, 6, 2, 3, 7,  1, 1, 24'h66280F, 0, 0, 1, 2};

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // cadence, latency, row crossing, ignored starts (busy and done cycles)
    first_tv = -1;
    ndone = 0;
    start_frame(2, 2, 2, 5, 0);
    for (int c = 1; c <= 30; c++) begin
      if (c >= 6 && c <= 25) begin
        check($sformatf("hs phase c%0d", c), 32'(phase), 32'((c - 6) % 5));
        check($sformatf("hs tap_valid c%0d", c), 32'(tap_valid), 32'(((c - 6) % 5) != 0));
      end
      check($sformatf("hs busy c%0d", c), 32'(busy), 32'(c <= 25));
      check($sformatf("hs done c%0d", c), 32'(done), 32'(c == 26));
      if (c == 16 || c == 17) check($sformatf("hs row1 addr c%0d", c), 32'(rom_addr), 32'd600);
      if (c == 18) check("hs row1 addr c18", 32'(rom_addr), 32'd601);
      if (tap_valid === 1'b1 && first_tv < 0) first_tv = c;
      if (done === 1'b1) ndone++;
      start = (c == 10 || c == 26);
      @(posedge CLK); #1;
    end
    start = 1'b0;
    check("hs first tap_valid latency", 32'(first_tv), 32'd7);
    check("hs done pulse count", 32'(ndone), 32'd1);

    // reset during RUN phase 2 of slot 1
    start_frame(3, 4, 1, 0, 0);
    repeat (12) begin @(posedge CLK); #1; end
    check("mid phase before reset", 32'(phase), 32'd2);
    check("mid X before reset", 32'(X_out), 32'hAA704A);
    RST = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (3) begin
      @(posedge CLK); #1;
      check("midrst no done", 32'(done), 32'd0);
    end
    #1;
    RST = 1'b1;
    run_vec(vecs[0], 100);
    run_vec(vecs[1], 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
